// File: rtl/tune_pkg.sv
// Shared widths, reset values and FSM encoding for the tuning scheduler.
package tune_pkg;

  localparam int PHASE_W = 20;
  localparam int GAIN_W  = 3;
  localparam int DWELL_W = 16;

  localparam logic [PHASE_W-1:0] DEFAULT_PHASE = 20'h312EB;
  localparam logic [GAIN_W-1:0]  DEFAULT_GAIN  = 3'd2;

  typedef enum logic [1:0] {
    MANUAL,
    SCAN_APPLY,
    SCAN_DWELL,
    LOCKED
  } state_t;

endpackage

// File: rtl/tune_scheduler_if.sv
// Bundle between the SPI config block / demodulator and the NCO/gain stage.
interface tune_scheduler_if;
  import tune_pkg::*;

  logic               tick;
  logic               man_valid;
  logic [PHASE_W-1:0] man_phase_inc;
  logic [GAIN_W-1:0]  man_gain;
  logic               scan_go;
  logic [PHASE_W-1:0] scan_start;
  logic [PHASE_W-1:0] scan_stop;
  logic [PHASE_W-1:0] scan_step;
  logic [DWELL_W-1:0] scan_dwell;
  logic               carrier;
  logic [PHASE_W-1:0] phase_inc;
  logic [GAIN_W-1:0]  gain;
  logic               cfg_strobe;
  logic               scanning;
  logic               locked;

  // Configuration / control side.
  modport master (
    output tick, man_valid, man_phase_inc, man_gain,
    output scan_go, scan_start, scan_stop, scan_step, scan_dwell, carrier,
    input  phase_inc, gain, cfg_strobe, scanning, locked
  );

  // Scheduler side.
  modport slave (
    input  tick, man_valid, man_phase_inc, man_gain,
    input  scan_go, scan_start, scan_stop, scan_step, scan_dwell, carrier,
    output phase_inc, gain, cfg_strobe, scanning, locked
  );
endinterface

// File: rtl/tune_next_chan.sv
// Next scan channel: add the step, wrap to start on carry-out or past stop.
module tune_next_chan
  import tune_pkg::*;
(
  input  logic [PHASE_W-1:0] cur,
  input  logic [PHASE_W-1:0] start,
  input  logic [PHASE_W-1:0] stop,
  input  logic [PHASE_W-1:0] step,
  output logic [PHASE_W-1:0] nxt
);

  logic [PHASE_W:0] sum;

  assign sum = {1'b0, cur} + {1'b0, step};
  assign nxt = (sum[PHASE_W] || (sum[PHASE_W-1:0] > stop)) ? start : sum[PHASE_W-1:0];

endmodule

// File: rtl/tune_scheduler.sv
// Tuning-word / gain sequencer: manual words or channel scan, applied on ticks.
module tune_scheduler
  import tune_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  tune_scheduler_if.slave bus
);

  state_t state_q, state_d;

  logic               man_pend_q, man_pend_d;
  logic [PHASE_W-1:0] pend_phase_q, pend_phase_d;
  logic [GAIN_W-1:0]  pend_gain_q, pend_gain_d;
  logic [PHASE_W-1:0] cur_q, cur_d;
  logic [PHASE_W-1:0] start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic               strobe_q, strobe_d;
  logic               scanning_q, scanning_d;
  logic               locked_q, locked_d;
  logic [PHASE_W-1:0] next_chan;
  logic               dwell_done;

  tune_next_chan u_next_chan (
    .cur   (cur_q),
    .start (start_q),
    .stop  (stop_q),
    .step  (step_q),
    .nxt   (next_chan)
  );

  assign dwell_done = (dwell_cnt_q == DWELL_W'(1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= MANUAL;
    else     state_q <= state_d;
  end

  // Next-state: manual word always wins, scan_go (re)starts, ticks advance the scan.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.man_valid) begin
      state_d = MANUAL;
    end else if (bus.scan_go) begin
      state_d = SCAN_APPLY;
    end else if (bus.tick) begin
      case (state_q)
        SCAN_APPLY: state_d = SCAN_DWELL;
        SCAN_DWELL: if (dwell_done && bus.carrier) state_d = LOCKED;
        default:    state_d = state_q;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    man_pend_d   = man_pend_q;
    pend_phase_d = pend_phase_q;
    pend_gain_d  = pend_gain_q;
    cur_d        = cur_q;
    start_d      = start_q;
    stop_d       = stop_q;
    step_d       = step_q;
    dwell_d      = dwell_q;
    dwell_cnt_d  = dwell_cnt_q;
    phase_d      = phase_q;
    gain_d       = gain_q;
    strobe_d     = 1'b0;
    scanning_d   = (state_d == SCAN_APPLY) || (state_d == SCAN_DWELL);
    locked_d     = (state_d == LOCKED);

    if (bus.man_valid) begin
      pend_phase_d = bus.man_phase_inc;
      pend_gain_d  = bus.man_gain;
      man_pend_d   = 1'b1;
    end

    if (state_q == MANUAL && bus.tick && (bus.man_valid || man_pend_q)) begin
      // A word captured in the tick cycle itself is applied straight away.
      phase_d    = bus.man_valid ? bus.man_phase_inc : pend_phase_q;
      gain_d     = bus.man_valid ? bus.man_gain : pend_gain_q;
      strobe_d   = 1'b1;
      man_pend_d = 1'b0;
    end

    if (!bus.man_valid && bus.scan_go) begin
      start_d = bus.scan_start;
      stop_d  = bus.scan_stop;
      step_d  = bus.scan_step;
      dwell_d = (bus.scan_dwell == '0) ? DWELL_W'(1) : bus.scan_dwell;
      // Resuming from a lock steps past the locked channel using the old shadows.
      cur_d   = (state_q == LOCKED) ? next_chan : bus.scan_start;
    end else if (!bus.man_valid && bus.tick) begin
      case (state_q)
        SCAN_APPLY: begin
          phase_d     = cur_q;
          dwell_cnt_d = dwell_q;
          strobe_d    = 1'b1;
        end
        SCAN_DWELL: begin
          if (!dwell_done) begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end else if (bus.carrier) begin
            dwell_cnt_d = '0;
          end else begin
            cur_d       = next_chan;
            phase_d     = next_chan;
            dwell_cnt_d = dwell_q;
            strobe_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      man_pend_q   <= 1'b0;
      pend_phase_q <= '0;
      pend_gain_q  <= '0;
      cur_q        <= '0;
      start_q      <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      phase_q      <= DEFAULT_PHASE;
      gain_q       <= DEFAULT_GAIN;
      strobe_q     <= 1'b0;
      scanning_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      man_pend_q   <= man_pend_d;
      pend_phase_q <= pend_phase_d;
      pend_gain_q  <= pend_gain_d;
      cur_q        <= cur_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      dwell_q      <= dwell_d;
      dwell_cnt_q  <= dwell_cnt_d;
      phase_q      <= phase_d;
      gain_q       <= gain_d;
      strobe_q     <= strobe_d;
      scanning_q   <= scanning_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.phase_inc  = phase_q;
  assign bus.gain       = gain_q;
  assign bus.cfg_strobe = strobe_q;
  assign bus.scanning   = scanning_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_tune_scheduler.sv
// Randomized bench for tune_scheduler against a tick-level behavioural model.
module tb_tune_scheduler;
  import tune_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  tune_scheduler_if bus();

  tune_scheduler dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobes = 0;
  logic [GAIN_W-1:0] exp_gain = DEFAULT_GAIN;

  always @(negedge CLK) if (bus.cfg_strobe === 1'b1) n_strobes++;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  // Reference channel stepping with plain integer arithmetic.
  function automatic logic [PHASE_W-1:0] ref_next(input logic [PHASE_W-1:0] c,
      input logic [PHASE_W-1:0] start, input logic [PHASE_W-1:0] stop,
      input logic [PHASE_W-1:0] stp);
    longint s;
    s = longint'(c) + longint'(stp);
    if (s > longint'(20'hFFFFF) || s > longint'(stop)) return start;
    return PHASE_W'(s);
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    idle(2);
    n_tests++; if (bus.phase_inc !== DEFAULT_PHASE) begin n_fail++; $display("FAIL reset_phase: got %h expected %h", bus.phase_inc, DEFAULT_PHASE); end
    n_tests++; if (bus.gain !== DEFAULT_GAIN) begin n_fail++; $display("FAIL reset_gain: got %0d expected %0d", bus.gain, DEFAULT_GAIN); end
    n_tests++; if ({bus.cfg_strobe, bus.scanning, bus.locked} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.cfg_strobe, bus.scanning, bus.locked}); end
    RST = 1'b0;
    step();
    exp_gain = DEFAULT_GAIN;
  endtask

  task automatic test_manual();
    int s0;
    bus.man_valid = 1'b1; bus.man_phase_inc = 20'h40000; bus.man_gain = 3'd5;
    step();
    bus.man_valid = 1'b0;
    s0 = n_strobes;
    idle(10);
    n_tests++; if (bus.phase_inc !== DEFAULT_PHASE || n_strobes != s0) begin n_fail++; $display("FAIL manual_hold: got %h/%0d strobes expected %h/0", bus.phase_inc, n_strobes - s0, DEFAULT_PHASE); end
    pulse_tick();
    n_tests++; if (bus.phase_inc !== 20'h40000) begin n_fail++; $display("FAIL manual_phase: got %h expected 40000", bus.phase_inc); end
    n_tests++; if (bus.gain !== 3'd5) begin n_fail++; $display("FAIL manual_gain: got %0d expected 5", bus.gain); end
    n_tests++; if (bus.cfg_strobe !== 1'b1) begin n_fail++; $display("FAIL manual_strobe: got %b expected 1", bus.cfg_strobe); end
    step();
    n_tests++; if (bus.cfg_strobe !== 1'b0 || n_strobes != s0 + 1) begin n_fail++; $display("FAIL manual_strobe_width: got %b/%0d expected 0/1", bus.cfg_strobe, n_strobes - s0); end
    exp_gain = 3'd5;
  endtask

  task automatic test_last_wins();
    logic [PHASE_W-1:0] ph;
    logic [GAIN_W-1:0]  g;
    int s0, np;
    bit same;
    for (int it = 0; it < 8; it++) begin
      np   = (it == 0) ? 2 : int'($urandom_range(1, 3));
      same = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      s0 = n_strobes;
      for (int p = 0; p < np; p++) begin
        ph = (it == 0) ? ((p == 0) ? 20'h11111 : 20'h22222) : PHASE_W'($urandom);
        g  = GAIN_W'($urandom);
        bus.man_valid = 1'b1; bus.man_phase_inc = ph; bus.man_gain = g;
        bus.tick = (same && p == np - 1);
        step();
        bus.man_valid = 1'b0; bus.tick = 1'b0;
        if (!(same && p == np - 1)) idle($urandom_range(0, 2));
      end
      if (!same) pulse_tick();
      n_tests++; if (bus.phase_inc !== ph || bus.gain !== g) begin n_fail++; $display("FAIL last_wins[%0d]: got %h/%0d expected %h/%0d", it, bus.phase_inc, bus.gain, ph, g); end
      step();
      n_tests++; if (n_strobes != s0 + 1) begin n_fail++; $display("FAIL last_wins_strobes[%0d]: got %0d expected 1", it, n_strobes - s0); end
      exp_gain = g;
    end
  endtask

  // Start (or restart) a scan and check nticks ticks; returns the last channel.
  task automatic run_scan(input logic [PHASE_W-1:0] start, input logic [PHASE_W-1:0] stop,
      input logic [PHASE_W-1:0] stp, input logic [DWELL_W-1:0] dwell, input int nticks,
      output logic [PHASE_W-1:0] ch);
    int d;
    bit exp_strobe;
    d = (dwell == 0) ? 1 : int'(dwell);
    bus.scan_start = start; bus.scan_stop = stop; bus.scan_step = stp; bus.scan_dwell = dwell;
    bus.scan_go = 1'b1;
    step();
    bus.scan_go = 1'b0;
    n_tests++; if (bus.scanning !== 1'b1 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL scan_enter: got scanning=%b locked=%b expected 1/0", bus.scanning, bus.locked); end
    ch = start;
    for (int k = 1; k <= nticks; k++) begin
      idle($urandom_range(0, 2));
      pulse_tick();
      exp_strobe = ((k - 1) % d == 0);
      if (k > 1 && exp_strobe) ch = ref_next(ch, start, stop, stp);
      n_tests++; if (bus.phase_inc !== ch || bus.cfg_strobe !== exp_strobe) begin n_fail++; $display("FAIL scan_tick[%0d]: got %h/%b expected %h/%b", k, bus.phase_inc, bus.cfg_strobe, ch, exp_strobe); end
      n_tests++; if (bus.scanning !== 1'b1 || bus.gain !== exp_gain) begin n_fail++; $display("FAIL scan_state[%0d]: got scanning=%b gain=%0d expected 1/%0d", k, bus.scanning, bus.gain, exp_gain); end
    end
  endtask

  task automatic test_scan();
    logic [PHASE_W-1:0] ch;
    run_scan(20'd100, 20'd130, 20'd10, 16'd2, 10, ch);
    run_scan(20'hFFFF0, 20'hFFFFF, 20'h20, 16'd1, 4, ch);
    run_scan(20'd500, 20'd900, 20'd0, 16'd1, 3, ch);
    run_scan(20'd900, 20'd500, 20'd7, 16'd0, 3, ch);
    for (int r = 0; r < 6; r++) begin
      logic [PHASE_W-1:0] a, b, s;
      a = PHASE_W'($urandom_range(0, 20'hFFFFF));
      b = PHASE_W'($urandom_range(0, 20'hFFFFF));
      s = PHASE_W'($urandom_range(0, 20'h3FFFF));
      run_scan(a, b, s, DWELL_W'($urandom_range(0, 3)), int'($urandom_range(4, 12)), ch);
    end
  endtask

  task automatic test_lock();
    logic [PHASE_W-1:0] ch;
    run_scan(20'd100, 20'd130, 20'd10, 16'd2, 5, ch);
    bus.carrier = 1'b1;
    pulse_tick();
    pulse_tick();
    n_tests++; if (bus.locked !== 1'b1 || bus.scanning !== 1'b0) begin n_fail++; $display("FAIL lock_flags: got locked=%b scanning=%b expected 1/0", bus.locked, bus.scanning); end
    n_tests++; if (bus.phase_inc !== 20'd120 || bus.cfg_strobe !== 1'b0) begin n_fail++; $display("FAIL lock_phase: got %0d/%b expected 120/0", bus.phase_inc, bus.cfg_strobe); end
    for (int i = 0; i < 3; i++) pulse_tick();
    n_tests++; if (bus.phase_inc !== 20'd120 || bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got %0d/%b expected 120/1", bus.phase_inc, bus.locked); end
    bus.carrier = 1'b0;
    bus.scan_go = 1'b1;
    step();
    bus.scan_go = 1'b0;
    n_tests++; if (bus.scanning !== 1'b1 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL resume_flags: got scanning=%b locked=%b expected 1/0", bus.scanning, bus.locked); end
    pulse_tick();
    n_tests++; if (bus.phase_inc !== 20'd130 || bus.cfg_strobe !== 1'b1) begin n_fail++; $display("FAIL resume_phase: got %0d/%b expected 130/1", bus.phase_inc, bus.cfg_strobe); end
  endtask

  task automatic test_back_to_back();
    logic [PHASE_W-1:0] ch, w;
    logic [GAIN_W-1:0]  g;
    run_scan(20'd100, 20'd130, 20'd10, 16'd2, 3, ch);
    w = PHASE_W'($urandom);
    g = GAIN_W'($urandom);
    bus.man_valid = 1'b1; bus.man_phase_inc = w; bus.man_gain = g; bus.scan_go = 1'b1;
    step();
    bus.man_valid = 1'b0; bus.scan_go = 1'b0;
    n_tests++; if (bus.scanning !== 1'b0 || bus.locked !== 1'b0 || bus.phase_inc !== ch) begin n_fail++; $display("FAIL priority_state: got scanning=%b phase=%h expected 0/%h", bus.scanning, bus.phase_inc, ch); end
    idle(2);
    pulse_tick();
    n_tests++; if (bus.phase_inc !== w || bus.gain !== g || bus.cfg_strobe !== 1'b1) begin n_fail++; $display("FAIL priority_apply: got %h/%0d/%b expected %h/%0d/1", bus.phase_inc, bus.gain, bus.cfg_strobe, w, g); end
    exp_gain = g;
    run_scan(20'd1000, 20'd5000, 20'd300, 16'd3, 4, ch);
    RST = 1'b1;
    #1;
    n_tests++; if (bus.phase_inc !== DEFAULT_PHASE || bus.gain !== DEFAULT_GAIN || bus.scanning !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %h/%0d/%b expected %h/%0d/0", bus.phase_inc, bus.gain, bus.scanning, DEFAULT_PHASE, DEFAULT_GAIN); end
    step();
    RST = 1'b0;
    step();
    exp_gain = DEFAULT_GAIN;
  endtask

  initial begin
    bus.tick = 1'b0; bus.man_valid = 1'b0; bus.man_phase_inc = '0; bus.man_gain = '0;
    bus.scan_go = 1'b0; bus.scan_start = '0; bus.scan_stop = '0; bus.scan_step = '0;
    bus.scan_dwell = '0; bus.carrier = 1'b0;
    test_reset();
    test_manual();
    test_last_wins();
    test_scan();
    test_lock();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
